// File: rtl/icache_refill_writer.sv
// icache_refill_writer: drives the I-cache data RF write port for line refills and a full-array zeroing flush.
// Optional REFILL_LAST_CHECK_EN: flags beat_last_i disagreeing with the beat counter on a sticky error_o.
module icache_refill_writer #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int BEATS_PER_LINE = 4,
   localparam int BEAT_W = $clog2(BEATS_PER_LINE),
   localparam int LINE_W = ADDR_WIDTH - BEAT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  refill_req_valid_i,
   output logic                  refill_req_ready_o,
   input  logic [LINE_W-1:0]     refill_req_line_i,
   input  logic                  beat_valid_i,
   output logic                  beat_ready_o,
   input  logic [DATA_WIDTH-1:0] beat_data_i,
   input  logic                  beat_last_i,
   input  logic                  flush_req_i,
   output logic                  flush_ack_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  refill_done_o,
   output logic                  busy_o,
   output logic                  error_o
);

   typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

   state_t                state;
   logic [LINE_W-1:0]     line_q;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic                  last_beat;

   assign last_beat = &beat_cnt;

   // A new request waits out the done cycle so the finished line is visible before the next starts.
   assign refill_req_ready_o = (state == IDLE) && !flush_req_i && !refill_done_o;
   assign beat_ready_o       = (state == FILL);
   assign busy_o             = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         line_q        <= '0;
         beat_cnt      <= '0;
         sweep_cnt     <= '0;
         we_o          <= 1'b0;
         waddr_o       <= '0;
         wdata_o       <= '0;
         refill_done_o <= 1'b0;
         flush_ack_o   <= 1'b0;
      end else begin
         we_o          <= 1'b0;
         refill_done_o <= 1'b0;
         flush_ack_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_req_i) begin
                  sweep_cnt <= '0;
                  state     <= FLUSH;
               end else if (refill_req_valid_i && refill_req_ready_o) begin
                  line_q   <= refill_req_line_i;
                  beat_cnt <= '0;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (beat_valid_i) begin
                  we_o     <= 1'b1;
                  waddr_o  <= {line_q, beat_cnt};
                  wdata_o  <= beat_data_i;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     refill_done_o <= 1'b1;
                     state         <= IDLE;
                  end
               end
            end
            FLUSH: begin
               we_o      <= 1'b1;
               waddr_o   <= sweep_cnt;
               wdata_o   <= '0;
               sweep_cnt <= sweep_cnt + 1'b1;
               if (&sweep_cnt) begin
                  flush_ack_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REFILL_LAST_CHECK_EN
   // Line length still follows the counter; the sender's marker is only audited.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         error_o <= 1'b0;
      else if (state == FILL && beat_valid_i && (beat_last_i != last_beat))
         error_o <= 1'b1;
   end
`else
   logic unused_beat_last;
   assign unused_beat_last = beat_last_i;
   assign error_o          = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_writer.sv
// Randomized bench for icache_refill_writer against an array-level model of the register file contents.
module tb_icache_refill_writer;
   localparam int AW = 5, DW = 32, BPL = 4, NW = 32, LW = 3;

   logic          clk = 1'b0, rst = 1'b1;
   logic          refill_req_valid_i = 1'b0, refill_req_ready_o;
   logic [LW-1:0] refill_req_line_i = '0;
   logic          beat_valid_i = 1'b0, beat_ready_o, beat_last_i = 1'b0;
   logic [DW-1:0] beat_data_i = '0;
   logic          flush_req_i = 1'b0, flush_ack_o, we_o, refill_done_o, busy_o, error_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;

   int            checks = 0, errors = 0;
   logic [DW-1:0] model_mem [NW];
   logic [DW-1:0] dut_mem [NW];
   logic          exp_err = 1'b0;

   icache_refill_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS_PER_LINE(BPL)) dut (
      .clk(clk), .rst(rst),
      .refill_req_valid_i(refill_req_valid_i), .refill_req_ready_o(refill_req_ready_o),
      .refill_req_line_i(refill_req_line_i),
      .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_data_i(beat_data_i),
      .beat_last_i(beat_last_i),
      .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
      .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .refill_done_o(refill_done_o), .busy_o(busy_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   // Shadow of what the register file actually captures on each rising edge.
   always @(posedge clk) if (we_o) dut_mem[waddr_o] <= wdata_o;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({we_o, refill_done_o, flush_ack_o, busy_o, error_o} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b exp 00000", {we_o, refill_done_o, flush_ack_o, busy_o, error_o}); end
      checks++; if ({waddr_o, wdata_o} !== '0) begin
         errors++; $display("FAIL reset_addr_data: got %h/%h exp 0/0", waddr_o, wdata_o); end
      checks++; if ({refill_req_ready_o, beat_ready_o} !== 2'b10) begin
         errors++; $display("FAIL reset_ready: got %b exp 10", {refill_req_ready_o, beat_ready_o}); end
      rst = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic refill_line(input int line, input logic [BPL-1:0][DW-1:0] d, input int gap,
                              input int last_pos, input int flush_after);
      int n;
      @(negedge clk);
      refill_req_valid_i = 1'b1;
      refill_req_line_i  = line[LW-1:0];
      #1; n = 0;
      while (!refill_req_ready_o && n < 50) begin @(negedge clk); #1; n++; end
      checks++; if (refill_req_ready_o !== 1'b1) begin
         errors++; $display("FAIL refill_accept: ready got %b exp 1 (line %0d)", refill_req_ready_o, line); end
      @(posedge clk);
      @(negedge clk);
      refill_req_valid_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin
         errors++; $display("FAIL fill_busy: got %b exp 1", busy_o); end
      for (int b = 0; b < BPL; b++) begin
         repeat (gap) begin
            @(posedge clk); @(negedge clk);
            checks++; if (we_o !== 1'b0) begin
               errors++; $display("FAIL gap_no_write: we got %b exp 0", we_o); end
         end
         beat_valid_i = 1'b1;
         beat_data_i  = d[b];
         beat_last_i  = (b == last_pos);
         #1;
         checks++; if (beat_ready_o !== 1'b1) begin
            errors++; $display("FAIL beat_ready: got %b exp 1", beat_ready_o); end
         @(posedge clk); @(negedge clk);
         beat_valid_i = 1'b0;
         beat_last_i  = 1'b0;
         model_mem[line*BPL + b] = d[b];
`ifdef REFILL_LAST_CHECK_EN
         if ((b == last_pos) != (b == BPL-1)) exp_err = 1'b1;
`endif
         checks++; if ({we_o, waddr_o, wdata_o, refill_done_o} !== {1'b1, 5'(line*BPL + b), d[b], (b == BPL-1)}) begin
            errors++; $display("FAIL beat_write: got we=%b a=%0d d=%h done=%b exp we=1 a=%0d d=%h done=%b",
                               we_o, waddr_o, wdata_o, refill_done_o, line*BPL + b, d[b], (b == BPL-1)); end
         checks++; if (error_o !== exp_err) begin
            errors++; $display("FAIL error_flag: got %b exp %b (beat %0d)", error_o, exp_err, b); end
         if (b == flush_after) flush_req_i = 1'b1;
      end
      #1;
      checks++; if (refill_req_ready_o !== 1'b0) begin
         errors++; $display("FAIL ready_in_done_cycle: got %b exp 0", refill_req_ready_o); end
      if (flush_after < 0) begin
         @(negedge clk);
         checks++; if ({busy_o, we_o, refill_done_o} !== 3'b000) begin
            errors++; $display("FAIL after_done: busy/we/done got %b exp 000", {busy_o, we_o, refill_done_o}); end
      end
   endtask

   // Call with flush_req_i already sampled-high in the IDLE cycle just ending.
   task automatic check_sweep();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!we_o && n < 6);
      checks++; if (n != 2) begin
         errors++; $display("FAIL sweep_latency: first write after %0d cycles exp 2", n); end
      for (int a = 0; a < NW; a++) begin
         checks++; if ({we_o, waddr_o, wdata_o, flush_ack_o} !== {1'b1, 5'(a), 32'h0, (a == NW-1)}) begin
            errors++; $display("FAIL sweep_write: got we=%b a=%0d d=%h ack=%b exp we=1 a=%0d d=0 ack=%b",
                               we_o, waddr_o, wdata_o, flush_ack_o, a, (a == NW-1)); end
         if (a == 10) begin
            beat_valid_i = 1'b1; refill_req_valid_i = 1'b1; #1;
            checks++; if ({beat_ready_o, refill_req_ready_o} !== 2'b00) begin
               errors++; $display("FAIL sweep_blocks: beat/refill ready got %b exp 00", {beat_ready_o, refill_req_ready_o}); end
            beat_valid_i = 1'b0; refill_req_valid_i = 1'b0;
         end
         if (a == NW-1) flush_req_i = 1'b0;
         else begin @(posedge clk); @(negedge clk); end
      end
      for (int i = 0; i < NW; i++) model_mem[i] = '0;
      @(negedge clk);
      checks++; if ({busy_o, we_o, flush_ack_o} !== 3'b000) begin
         errors++; $display("FAIL sweep_end: busy/we/ack got %b exp 000", {busy_o, we_o, flush_ack_o}); end
   endtask

   task automatic test_basic_refill();
      refill_line(3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, BPL-1, -1);
   endtask

   task automatic test_gapped_refill();
      refill_line(3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, BPL-1, -1);
   endtask

   task automatic test_flush_vs_refill();
      @(negedge clk);
      flush_req_i = 1'b1; refill_req_valid_i = 1'b1; refill_req_line_i = 3'd5;
      #1;
      checks++; if (refill_req_ready_o !== 1'b0) begin
         errors++; $display("FAIL flush_priority: refill ready got %b exp 0", refill_req_ready_o); end
      check_sweep();
      refill_line(5, {$urandom, $urandom, $urandom, $urandom}, 0, BPL-1, -1);
   endtask

   task automatic test_flush_during_fill();
      refill_line(1, {$urandom, $urandom, $urandom, $urandom}, 0, BPL-1, 1);
      check_sweep();
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++) begin
         refill_line(int'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
                     int'($urandom_range(0, 2)), BPL-1, -1);
         if (k == 6) begin
            @(negedge clk); flush_req_i = 1'b1;
            check_sweep();
         end
      end
   endtask

   task automatic test_last_check();
      refill_line(2, {$urandom, $urandom, $urandom, $urandom}, 0, 1, -1);
      refill_line(6, {$urandom, $urandom, $urandom, $urandom}, 1, BPL-1, -1);
   endtask

   task automatic test_array_contents();
      repeat (2) @(negedge clk);
      for (int i = 0; i < NW; i++) begin
         checks++; if (dut_mem[i] !== model_mem[i]) begin
            errors++; $display("FAIL array_word: addr %0d got %h exp %h", i, dut_mem[i], model_mem[i]); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      @(negedge clk); flush_req_i = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(we_o && waddr_o == 5'd10) && n < 40);
      checks++; if (!(we_o === 1'b1 && waddr_o === 5'd10)) begin
         errors++; $display("FAIL sweep_reach10: got we=%b a=%0d exp we=1 a=10", we_o, waddr_o); end
      rst = 1'b1; flush_req_i = 1'b0;
      #1;
      checks++; if ({we_o, waddr_o, wdata_o, refill_done_o, flush_ack_o, busy_o, error_o} !== '0) begin
         errors++; $display("FAIL reset_mid_sweep: got we=%b a=%h d=%h done=%b ack=%b busy=%b err=%b exp all 0",
                            we_o, waddr_o, wdata_o, refill_done_o, flush_ack_o, busy_o, error_o); end
      for (int i = 0; i < 10; i++) model_mem[i] = '0;
      exp_err = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++; if ({we_o, flush_ack_o, busy_o} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle: we/ack/busy got %b exp 000", {we_o, flush_ack_o, busy_o}); end
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) model_mem[i] = '0;
      test_reset();
      test_basic_refill();
      test_gapped_refill();
      test_flush_vs_refill();
      test_flush_during_fill();
      test_random();
      test_last_check();
      test_array_contents();
      test_reset_mid_sweep();
      refill_line(0, {$urandom, $urandom, $urandom, $urandom}, 0, BPL-1, -1);
      test_array_contents();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
